// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// the control FSM state type and the funct3 legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic legal;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/halfword handling: load extraction with sign/zero
// extension, and read-modify-write merge of narrow store data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] base_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    always_comb begin
        load_data_o = 32'd0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{rd_word_i[7]}}, rd_word_i[7:0]};
            F3_H:    load_data_o = {{16{rd_word_i[15]}}, rd_word_i[15:0]};
            F3_W:    load_data_o = rd_word_i;
            F3_BU:   load_data_o = {24'd0, rd_word_i[7:0]};
            F3_HU:   load_data_o = {16'd0, rd_word_i[15:0]};
            default: load_data_o = 32'd0;
        endcase
    end

    // Narrow stores keep the upper bytes of the word read back from memory.
    always_comb begin
        store_word_o = 32'd0;
        case (funct3_i)
            F3_B:    store_word_o = {base_word_i[31:8], wdata_i[7:0]};
            F3_H:    store_word_o = {base_word_i[31:16], wdata_i[15:0]};
            F3_W:    store_word_o = wdata_i;
            default: store_word_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time through IDLE/READ/WRITE/RESP,
// with read-modify-write for byte and halfword stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_SIZE  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [8*BYTE_SIZE-1:0]  req_wdata,
    output logic                    resp_valid,
    output logic [8*BYTE_SIZE-1:0]  resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_ADDR,
    output logic                    mem_WE,
    output logic [8*BYTE_SIZE-1:0]  mem_WD,
    input  logic [8*BYTE_SIZE-1:0]  mem_RD
);

    localparam int WORD_W = 8 * BYTE_SIZE;

    lsu_state_e              state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [WORD_W-1:0]       wdata_q;
    logic [WORD_W-1:0]       word_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic [WORD_W-1:0]       resp_rdata_q;

    logic [WORD_W-1:0]       load_data_d;
    logic [WORD_W-1:0]       store_word_d;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .rd_word_i    (mem_RD),
        .base_word_i  (word_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_d),
        .store_word_o (store_word_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            wdata_q      <= '0;
            word_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        if (!funct3_legal(req_we, req_funct3)) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    word_q <= mem_RD;
                    if (we_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data_d;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory controls decode straight from the state register, so an
    // asynchronous reset during WRITE withdraws mem_WE before the next edge.
    always_comb begin
        mem_ADDR = '0;
        mem_WE   = 1'b0;
        mem_WD   = '0;
        if (state_q == READ) begin
            mem_ADDR = addr_q;
        end else if (state_q == WRITE) begin
            mem_ADDR = addr_q;
            mem_WE   = 1'b1;
            mem_WD   = store_word_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-addressed memory model, a table
// of request vectors, and hand sequences for held req_valid and mid-write reset.
module tb_load_store_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_ADDR;
    logic          mem_WE;
    logic [31:0]   mem_WD;
    logic [31:0]   mem_RD;

    load_store_unit #(.ADDR_WIDTH(AW), .BYTE_SIZE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ADDR   (mem_ADDR),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    always #5 clk = ~clk;

    // 256-byte little-endian memory, index wraps within the low address byte
    logic [7:0] mem [0:255];
    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] ra0, ra1, ra2, ra3;

    assign ra0 = mem_ADDR[7:0];
    assign ra1 = mem_ADDR[7:0] + 8'd1;
    assign ra2 = mem_ADDR[7:0] + 8'd2;
    assign ra3 = mem_ADDR[7:0] + 8'd3;
    assign mem_RD = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_WE) begin
            mem[ra0] <= mem_WD[7:0];
            mem[ra1] <= mem_WD[15:8];
            mem[ra2] <= mem_WD[23:16];
            mem[ra3] <= mem_WD[31:24];
        end
    end

    int we_total  = 0;
    int act_total = 0;
    int rv_total  = 0;

    always @(posedge clk) begin
        if (mem_WE) we_total = we_total + 1;
        if (mem_WE || (mem_ADDR != '0) || (mem_WD != 32'd0)) act_total = act_total + 1;
        if (resp_valid) rv_total = rv_total + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Presents one request in IDLE and returns edges from acceptance to resp_valid.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit hold, input string tag,
                           output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        if (!resp_valid) lat = 99;
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          wes;
    } vec_t;

    localparam int NV = 18;
    vec_t v [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          we0, act0, rv0;
        logic [7:0]  save [4];

        v[0]  = '{1'b0, 3'd0, 32'h10, 32'h0,        2, 32'hFFFFFFF3, 1'b0, 0};
        v[1]  = '{1'b0, 3'd4, 32'h11, 32'h0,        2, 32'h00000082, 1'b0, 0};
        v[2]  = '{1'b0, 3'd1, 32'h12, 32'h0,        2, 32'hFFFF8081, 1'b0, 0};
        v[3]  = '{1'b0, 3'd5, 32'h12, 32'h0,        2, 32'h00008081, 1'b0, 0};
        v[4]  = '{1'b0, 3'd2, 32'h10, 32'h0,        2, 32'h808182F3, 1'b0, 0};
        v[5]  = '{1'b1, 3'd0, 32'h10, 32'h123456AB, 3, 32'h00000000, 1'b0, 1};
        v[6]  = '{1'b0, 3'd2, 32'h10, 32'h0,        2, 32'h808182AB, 1'b0, 0};
        v[7]  = '{1'b1, 3'd2, 32'h21, 32'hDEADBEEF, 2, 32'h00000000, 1'b0, 1};
        v[8]  = '{1'b0, 3'd2, 32'h21, 32'h0,        2, 32'hDEADBEEF, 1'b0, 0};
        v[9]  = '{1'b0, 3'd3, 32'h10, 32'h0,        1, 32'h00000000, 1'b1, 0};
        v[10] = '{1'b1, 3'd1, 32'h12, 32'h9999BEEF, 3, 32'h00000000, 1'b0, 1};
        v[11] = '{1'b0, 3'd2, 32'h10, 32'h0,        2, 32'hBEEF82AB, 1'b0, 0};
        v[12] = '{1'b1, 3'd3, 32'h40, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1, 0};
        v[13] = '{1'b0, 3'd0, 32'h13, 32'h0,        2, 32'hFFFFFFBE, 1'b0, 0};
        v[14] = '{1'b0, 3'd5, 32'h11, 32'h0,        2, 32'h0000EF82, 1'b0, 0};
        v[15] = '{1'b0, 3'd7, 32'h10, 32'h0,        1, 32'h00000000, 1'b1, 0};
        v[16] = '{1'b1, 3'd5, 32'h10, 32'h55555555, 1, 32'h00000000, 1'b1, 0};
        v[17] = '{1'b0, 3'd1, 32'h22, 32'h0,        2, 32'hFFFFADBE, 1'b0, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = 32'd0;
        pl_en      = 1'b0;
        pl_addr    = 8'd0;
        pl_data    = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",      {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_mem_we",     {31'd0, mem_WE},     32'd0);
        check("rst_mem_addr",   mem_ADDR,            32'd0);
        check("rst_mem_wd",     mem_WD,              32'd0);

        for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
        preload(8'h10, 8'hF3);
        preload(8'h11, 8'h82);
        preload(8'h12, 8'h81);
        preload(8'h13, 8'h80);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            we0  = we_total;
            act0 = act_total;
            run_req(v[i].we, v[i].f3, v[i].addr, v[i].wd, 1'b0, $sformatf("v%0d", i), lat, rd, er);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
            check($sformatf("v%0d_rdata", i), rd, v[i].rdata);
            check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, v[i].err});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse_end", i), {31'd0, resp_valid}, 32'd0);
            check($sformatf("v%0d_rdata_hold", i), resp_rdata, v[i].rdata);
            check($sformatf("v%0d_err_hold", i), {31'd0, resp_err}, {31'd0, v[i].err});
            check($sformatf("v%0d_we_pulses", i), 32'(we_total - we0), 32'(v[i].wes));
            if (v[i].err) begin
                check($sformatf("v%0d_no_mem_activity", i), 32'(act_total - act0), 32'd0);
            end
        end

        // req_valid held high through READ and RESP must yield a single response
        rv0 = rv_total;
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, "hold", lat, rd, er);
        check("hold_latency", 32'(lat), 32'd2);
        check("hold_rdata", rd, 32'hBEEF82AB);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("hold_ready_again", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("hold_single_resp", 32'(rv_total - rv0), 32'd1);

        // reset while an SH sits in WRITE: no commit, no response
        for (int k = 0; k < 4; k++) save[k] = mem[8'h10 + 8'(k)];
        rv0 = rv_total;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = 32'h10;
        req_wdata  = 32'h00001111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sh_in_write_we", {31'd0, mem_WE}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_we_dropped",  {31'd0, mem_WE},    32'd0);
        check("rstw_addr_zero",   mem_ADDR,           32'd0);
        check("rstw_wd_zero",     mem_WD,             32'd0);
        check("rstw_ready_async", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_ready_after", {31'd0, req_ready}, 32'd1);
        check("rstw_no_resp", 32'(rv_total - rv0), 32'd0);
        check("rstw_rdata_cleared", resp_rdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rstw_mem_byte%0d", k), {24'd0, mem[8'h10 + 8'(k)]}, {24'd0, save[k]});
        end

        run_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, "post", lat, rd, er);
        check("post_latency", 32'(lat), 32'd2);
        check("post_rdata", rd, 32'hBEEF82AB);
        check("post_err", {31'd0, er}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
